// File: rtl/fetch_decode_stage.sv
// Y86-64 fetch-side PC select/predict register and F/D pipeline register.
// Optional instruction-issue counter is compiled in when FD_PERF_CNT_EN is defined.
module fetch_decode_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  input  logic [2:0]       f_stat,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic [3:0]       M_icode,
  input  logic             M_cnd,
  input  logic [63:0]      M_valA,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valM,
  output logic [63:0]      pc,
  output logic [63:0]      F_predPC,
  output logic [2:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [63:0]      D_valC,
  output logic [63:0]      D_valP,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [2:0] S_AOK  = 3'd1;

  logic [63:0] f_pred_pc;
  logic [63:0] pred_pc_q, pred_pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;

  // Jumps and calls are predicted taken.
  always_comb begin
    f_pred_pc = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL) f_pred_pc = f_valC;
  end

  // A not-taken jump resolving in M outranks a return completing in W.
  always_comb begin
    pc = pred_pc_q;
    if (M_icode == I_JXX && !M_cnd)  pc = M_valA;
    else if (W_icode == I_RET)       pc = W_valM;
  end

  always_comb begin
    pred_pc_d = pred_pc_q;
    if (!F_stall) pred_pc_d = f_pred_pc;
  end

  // Stall outranks bubble so a held instruction is never squashed.
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    if (D_stall) begin
      stat_d = stat_q;
    end else if (D_bubble) begin
      stat_d  = S_AOK;
      icode_d = I_NOP;
      ifun_d  = 4'h0;
      ra_d    = R_NONE;
      rb_d    = R_NONE;
      valc_d  = 64'd0;
      valp_d  = 64'd0;
    end else begin
      stat_d  = f_stat;
      icode_d = f_icode;
      ifun_d  = f_ifun;
      ra_d    = f_rA;
      rb_d    = f_rB;
      valc_d  = f_valC;
      valp_d  = f_valP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= 64'd0;
      stat_q    <= S_AOK;
      icode_q   <= I_NOP;
      ifun_q    <= 4'h0;
      ra_q      <= R_NONE;
      rb_q      <= R_NONE;
      valc_q    <= 64'd0;
      valp_q    <= 64'd0;
    end else begin
      pred_pc_q <= pred_pc_d;
      stat_q    <= stat_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      valc_q    <= valc_d;
      valp_q    <= valp_d;
    end
  end

  assign F_predPC = pred_pc_q;
  assign D_stat   = stat_q;
  assign D_icode  = icode_q;
  assign D_ifun   = ifun_q;
  assign D_rA     = ra_q;
  assign D_rB     = rb_q;
  assign D_valC   = valc_q;
  assign D_valP   = valp_q;

`ifdef FD_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             d_load;

  // Counts only real issues into D; saturates rather than wrapping.
  always_comb begin
    d_load        = !D_stall && !D_bubble;
    instr_count_d = instr_count_q;
    if (d_load && !(&instr_count_q)) instr_count_d = instr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_count_q <= '0;
    else        instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = '0;
`endif

endmodule
